cap_seq_ctl: RTL

Next-generation capture sequencer for the PL acquisition chain. On a trigger it sweeps gain settings 0..gain_number and handshakes a gain-set stage and a data-capture stage at each step. The whole sweep repeats rep_number+1 times. Adds per-handshake timeout, abort, error reporting and saturating capture-duration measurement. It sits between the trigger source and the gain/ADC capture engines.

---
 rtl/cap_seq_pkg.sv | 17 +
 rtl/cap_seq_wdog.sv | 35 +++
 rtl/cap_seq_ctl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cap_seq_pkg.sv
// Shared types and constants for the capture sequencer.
package cap_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAIN = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } cap_state_e;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_TMO   = 2'd1;
  localparam logic [1:0] ERR_ABORT = 2'd2;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/cap_seq_wdog.sv
// Per-handshake wait counter; flags expiry on the cycle the wait reaches the limit.
module cap_seq_wdog #(
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [TMO_W-1:0] limit_i,
  output logic             expired_c
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Counter holds the number of completed wait cycles; saturates so a disabled limit never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = run_i && (limit_i != '0) && (cnt_q == (limit_i - TMO_W'(1)));

endmodule

// File: rtl/cap_seq_ctl.sv
// Capture sequencer: gain sweep x repeat with gain/data handshakes, timeout, abort and duration.
// Optional CAP_SEQ_STATS_EN adds saturating ok/error completion counters (stat_ok, stat_err).
module cap_seq_ctl
  import cap_seq_pkg::*;
#(
  parameter int unsigned GAIN_W = 4,
  parameter int unsigned REP_W  = 8,
  parameter int unsigned TMO_W  = 16,
  parameter int unsigned TIME_W = 32
) (
  input  logic              clk125,
  input  logic              rst_n,
  input  logic              cap_trig,
  input  logic              cap_abort,
  input  logic [GAIN_W-1:0] gain_number,
  input  logic [REP_W-1:0]  rep_number,
  input  logic [TMO_W-1:0]  tmo_limit,
  output logic              cap_cing,
  output logic              cap_cmpt,
  output logic [1:0]        cap_err,
  output logic [TIME_W-1:0] cap_time,
  output logic [GAIN_W-1:0] gain_value,
  output logic [REP_W-1:0]  rep_value,
  output logic              gain_en,
  input  logic              gain_cmpt,
  output logic              data_en,
  input  logic              data_cmpt
`ifdef CAP_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_err
`endif
);

  cap_state_e        state_q, state_d;
  logic [GAIN_W-1:0] gain_num_q, gain_num_d;
  logic [REP_W-1:0]  rep_num_q, rep_num_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              cap_cing_q, cap_cing_d;
  logic              cap_cmpt_q, cap_cmpt_d;
  logic [1:0]        cap_err_q, cap_err_d;
  logic [TIME_W-1:0] cap_time_q, cap_time_d;
  logic [TIME_W-1:0] dur_q, dur_d;
  logic [TIME_W-1:0] dur_inc;
  logic [GAIN_W-1:0] gain_value_q, gain_value_d;
  logic [REP_W-1:0]  rep_value_q, rep_value_d;
  logic              gain_en_q, gain_en_d;
  logic              data_en_q, data_en_d;

  logic              wd_clear;
  logic              wd_run;
  logic              wd_expired_c;

  cap_seq_wdog #(
    .TMO_W (TMO_W)
  ) u_wdog (
    .clk       (clk125),
    .rst_n     (rst_n),
    .clear_i   (wd_clear),
    .run_i     (wd_run),
    .limit_i   (tmo_q),
    .expired_c (wd_expired_c)
  );

  assign wd_run   = (state_q == ST_GAIN) || (state_q == ST_DATA);
  assign wd_clear = (state_d != state_q) && ((state_d == ST_GAIN) || (state_d == ST_DATA));

  assign dur_inc  = (dur_q == '1) ? dur_q : (dur_q + TIME_W'(1));

  // Next-state and output logic; abort beats cmpt, cmpt beats timeout.
  always_comb begin
    state_d      = state_q;
    gain_num_d   = gain_num_q;
    rep_num_d    = rep_num_q;
    tmo_d        = tmo_q;
    cap_cing_d   = cap_cing_q;
    cap_cmpt_d   = 1'b0;
    cap_err_d    = cap_err_q;
    cap_time_d   = cap_time_q;
    gain_value_d = gain_value_q;
    rep_value_d  = rep_value_q;
    gain_en_d    = gain_en_q;
    data_en_d    = data_en_q;

    case (state_q)
      ST_IDLE: begin
        if (cap_trig) begin
          gain_num_d   = gain_number;
          rep_num_d    = rep_number;
          tmo_d        = tmo_limit;
          cap_err_d    = ERR_OK;
          gain_value_d = '0;
          rep_value_d  = '0;
          cap_cing_d   = 1'b1;
          gain_en_d    = 1'b1;
          state_d      = ST_GAIN;
        end
      end

      ST_GAIN: begin
        if (cap_abort) begin
          cap_err_d  = ERR_ABORT;
          gain_en_d  = 1'b0;
          data_en_d  = 1'b0;
          cap_cmpt_d = 1'b1;
          state_d    = ST_DONE;
        end else if (gain_cmpt) begin
          gain_en_d  = 1'b0;
          data_en_d  = 1'b1;
          state_d    = ST_DATA;
        end else if (wd_expired_c) begin
          cap_err_d  = ERR_TMO;
          gain_en_d  = 1'b0;
          data_en_d  = 1'b0;
          cap_cmpt_d = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_DATA: begin
        if (cap_abort) begin
          cap_err_d  = ERR_ABORT;
          gain_en_d  = 1'b0;
          data_en_d  = 1'b0;
          cap_cmpt_d = 1'b1;
          state_d    = ST_DONE;
        end else if (data_cmpt) begin
          data_en_d = 1'b0;
          if (gain_value_q < gain_num_q) begin
            gain_value_d = gain_value_q + GAIN_W'(1);
            gain_en_d    = 1'b1;
            state_d      = ST_GAIN;
          end else if (rep_value_q < rep_num_q) begin
            gain_value_d = '0;
            rep_value_d  = rep_value_q + REP_W'(1);
            gain_en_d    = 1'b1;
            state_d      = ST_GAIN;
          end else begin
            cap_cmpt_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else if (wd_expired_c) begin
          cap_err_d  = ERR_TMO;
          gain_en_d  = 1'b0;
          data_en_d  = 1'b0;
          cap_cmpt_d = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        // dur_q lags cap_cing by one cycle, so the exit cycle is added here.
        cap_cing_d = 1'b0;
        cap_time_d = dur_inc;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    dur_d = cap_cing_q ? dur_inc : '0;
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gain_num_q   <= '0;
      rep_num_q    <= '0;
      tmo_q        <= '0;
      cap_cing_q   <= 1'b0;
      cap_cmpt_q   <= 1'b0;
      cap_err_q    <= ERR_OK;
      cap_time_q   <= '0;
      dur_q        <= '0;
      gain_value_q <= '0;
      rep_value_q  <= '0;
      gain_en_q    <= 1'b0;
      data_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gain_num_q   <= gain_num_d;
      rep_num_q    <= rep_num_d;
      tmo_q        <= tmo_d;
      cap_cing_q   <= cap_cing_d;
      cap_cmpt_q   <= cap_cmpt_d;
      cap_err_q    <= cap_err_d;
      cap_time_q   <= cap_time_d;
      dur_q        <= dur_d;
      gain_value_q <= gain_value_d;
      rep_value_q  <= rep_value_d;
      gain_en_q    <= gain_en_d;
      data_en_q    <= data_en_d;
    end
  end

  assign cap_cing   = cap_cing_q;
  assign cap_cmpt   = cap_cmpt_q;
  assign cap_err    = cap_err_q;
  assign cap_time   = cap_time_q;
  assign gain_value = gain_value_q;
  assign rep_value  = rep_value_q;
  assign gain_en    = gain_en_q;
  assign data_en    = data_en_q;

`ifdef CAP_SEQ_STATS_EN
  logic [STAT_W-1:0] stat_ok_q, stat_ok_d;
  logic [STAT_W-1:0] stat_err_q, stat_err_d;

  // Completion counters sample the cap_cmpt pulse together with the final error code.
  always_comb begin
    stat_ok_d  = stat_ok_q;
    stat_err_d = stat_err_q;
    if (cap_cmpt_q) begin
      if (cap_err_q == ERR_OK) begin
        if (stat_ok_q != '1) stat_ok_d = stat_ok_q + STAT_W'(1);
      end else begin
        if (stat_err_q != '1) stat_err_d = stat_err_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_err = stat_err_q;
`endif

endmodule
